sys_output_collector: RTL and testbench

Parametrised, double-banked result collector for the systolic array's output edge. It captures the column-skewed result stream on every DSP_DELAY-th load cycle, de-skews it into complete rows, and stores up to two tiles in ping-pong banks. Completed tiles drain row by row over a valid/ready stream while the other bank fills. It sits between the array's bottom edge and the writeback/DMA path.

---
 rtl/sys_output_collector.sv | 121 ++++++++++++
 tb/tb_sys_output_collector.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_output_collector.sv
// Ping-pong result collector for the systolic array's bottom edge: de-skews the
// column-skewed result stream into rows and drains completed tiles over valid/ready.
module sys_output_collector #(
    parameter int ARRAY_W   = 4,
    parameter int DATA_W    = 32,
    parameter int DSP_DELAY = 3,
    parameter int ROWS      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_en,
    input  logic [ARRAY_W*DATA_W-1:0] in_res,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ARRAY_W*DATA_W-1:0] out_data,
    output logic                      out_last,
    output logic                      overflow
);
    localparam int NSTR = ROWS + ARRAY_W - 1;
    localparam int PH_W = (DSP_DELAY > 1) ? $clog2(DSP_DELAY) : 1;
    localparam int S_W  = $clog2(NSTR);
    localparam int R_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DSP_DELAY - 1);
    localparam logic [S_W-1:0]  S_LAST  = S_W'(NSTR - 1);
    localparam logic [S_W-1:0]  S_ROWS  = S_W'(ROWS);
    localparam logic [R_W-1:0]  R_LAST  = R_W'(ROWS - 1);

    logic [PH_W-1:0] ph;
    logic [S_W-1:0]  s;
    logic [R_W-1:0]  rrow;
    logic            wbank;
    logic            rbank;
    logic [1:0]      full;
    logic [1:0]      full_next;
    logic            strobe;
    logic            last_strobe;
    logic            accept;
    logic            last_accept;

    assign in_ready    = !full[wbank];
    assign out_valid   = full[rbank];
    assign out_last    = out_valid && (rrow == R_LAST);
    assign strobe      = load_en && in_ready && (ph == '0);
    assign last_strobe = strobe && (s == S_LAST);
    assign accept      = out_valid && out_ready;
    assign last_accept = accept && (rrow == R_LAST);

    // Tile completion and drain completion always target different banks, so both may apply at once.
    always_comb begin
        full_next = full;
        if (last_strobe) begin
            full_next[wbank] = 1'b1;
        end
        if (last_accept) begin
            full_next[rbank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph       <= '0;
            s        <= '0;
            rrow     <= '0;
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            full     <= 2'b00;
            overflow <= 1'b0;
        end else begin
            full <= full_next;
            if (load_en && !in_ready) begin
                overflow <= 1'b1;
            end
            if (load_en && in_ready) begin
                if (last_strobe || ph == PH_LAST) begin
                    ph <= '0;
                end else begin
                    ph <= ph + 1'b1;
                end
            end
            if (strobe) begin
                s <= last_strobe ? '0 : s + 1'b1;
            end
            if (last_strobe) begin
                wbank <= ~wbank;
            end
            if (accept) begin
                rrow <= last_accept ? '0 : rrow + 1'b1;
            end
            if (last_accept) begin
                rbank <= ~rbank;
            end
        end
    end

    // Lane c lags lane 0 by c strobes, so strobe s carries row s-c for lane c.
    for (genvar c = 0; c < ARRAY_W; c++) begin : g_lane
        localparam logic [S_W-1:0] C_S = S_W'(c);

        logic [DATA_W-1:0] mem [2][ROWS];
        logic [S_W-1:0]    diff;
        logic              in_win;
        logic [R_W-1:0]    wrow;

        assign diff   = s - C_S;
        assign in_win = (s >= C_S) && (diff < S_ROWS);
        assign wrow   = R_W'(diff);

        always_ff @(posedge clk) begin
            if (rst) begin
                mem <= '{default: '0};
            end else if (strobe && in_win) begin
                mem[wbank][wrow] <= in_res[c*DATA_W +: DATA_W];
            end
        end

        assign out_data[c*DATA_W +: DATA_W] = mem[rbank][rrow];
    end

endmodule

// File: tb/tb_sys_output_collector.sv
// Directed bench for sys_output_collector: a vector table for the basic tile plus
// hand-written sequences for gaps, ping-pong, backpressure, overlap, reset and a second parameter set.
module tb_sys_output_collector;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int RW  = 4;
    localparam int BW  = AW * DW;
    localparam int AW2 = 8;
    localparam int DW2 = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic          out_ready;
    logic [BW-1:0] in_res;
    logic          in_ready;
    logic          out_valid;
    logic          out_last;
    logic          overflow;
    logic [BW-1:0] out_data;

    logic          load_en_b;
    logic          out_ready_b;
    logic [BW-1:0] in_res_b;
    logic          in_ready_b;
    logic          out_valid_b;
    logic          out_last_b;
    logic          overflow_b;
    logic [BW-1:0] out_data_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          load_en;
        logic          out_ready;
        logic [BW-1:0] in_res;
        logic          exp_in_ready;
        logic          exp_valid;
        logic          exp_last;
        logic          exp_overflow;
        logic          chk_data;
        logic [BW-1:0] exp_data;
    } vec_t;

    vec_t vecs [23];

    always #5 clk = ~clk;

    sys_output_collector #(.ARRAY_W(AW), .DATA_W(DW), .DSP_DELAY(3), .ROWS(RW)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .in_res(in_res), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .overflow(overflow)
    );

    sys_output_collector #(.ARRAY_W(AW2), .DATA_W(DW2), .DSP_DELAY(1), .ROWS(2)) dut_b (
        .clk(clk), .rst(rst), .load_en(load_en_b), .in_res(in_res_b), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_last(out_last_b), .overflow(overflow_b)
    );

    // Lane c at load cycle k carries base + 16*k + c.
    function automatic logic [BW-1:0] pat(input int base, input int k);
        logic [BW-1:0] v;
        v = '0;
        for (int c = 0; c < AW; c++) v[c*DW +: DW] = DW'(base + 16*k + c);
        return v;
    endfunction

    function automatic logic [BW-1:0] row_exp(input int base, input int r);
        logic [BW-1:0] v;
        v = '0;
        for (int c = 0; c < AW; c++) v[c*DW +: DW] = DW'(base + 16*(3*(r+c)) + c);
        return v;
    endfunction

    function automatic logic [BW-1:0] pat_b(input int k);
        logic [BW-1:0] v;
        v = '0;
        for (int c = 0; c < AW2; c++) v[c*DW2 +: DW2] = DW2'(16*k + c);
        return v;
    endfunction

    function automatic logic [BW-1:0] row_b(input int r);
        logic [BW-1:0] v;
        v = '0;
        for (int c = 0; c < AW2; c++) v[c*DW2 +: DW2] = DW2'(16*(r+c) + c);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic le, input logic rdy, input logic [BW-1:0] d);
        load_en   = le;
        out_ready = rdy;
        in_res    = d;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        load_en_b = 1'b0;
        out_ready_b = 1'b0;
        in_res_b = '0;
        applyStimulus(1'b0, 1'b0, '0);
        rst = 1'b0;
    endtask

    task automatic fillTile(input int base, input logic rdy);
        for (int k = 0; k < 19; k++) applyStimulus(1'b1, rdy, pat(base, k));
    endtask

    task automatic drainCheck(input int base, input string tag);
        for (int r = 0; r < RW; r++) begin
            checkOutput($sformatf("%s valid r%0d", tag, r), out_valid, 1'b1);
            checkOutput($sformatf("%s data r%0d", tag, r), out_data, row_exp(base, r));
            checkOutput($sformatf("%s last r%0d", tag, r), out_last, r == RW - 1);
            applyStimulus(1'b0, 1'b1, '0);
        end
        checkOutput($sformatf("%s valid after drain", tag), out_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc;
        logic rdy;

        for (int k = 0; k < 19; k++) begin
            vecs[k].load_en      = 1'b1;
            vecs[k].out_ready    = 1'b1;
            vecs[k].in_res       = pat(0, k);
            vecs[k].exp_in_ready = 1'b1;
            vecs[k].exp_valid    = (k == 18);
            vecs[k].exp_last     = 1'b0;
            vecs[k].exp_overflow = 1'b0;
            vecs[k].chk_data     = (k == 18);
            vecs[k].exp_data     = row_exp(0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            vecs[19+i].load_en      = 1'b0;
            vecs[19+i].out_ready    = 1'b1;
            vecs[19+i].in_res       = '0;
            vecs[19+i].exp_in_ready = 1'b1;
            vecs[19+i].exp_valid    = (i < 3);
            vecs[19+i].exp_last     = (i == 2);
            vecs[19+i].exp_overflow = 1'b0;
            vecs[19+i].chk_data     = (i < 3);
            vecs[19+i].exp_data     = row_exp(0, i + 1);
        end

        doReset();
        checkOutput("reset in_ready", in_ready, 1'b1);
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset out_last", out_last, 1'b0);
        checkOutput("reset overflow", overflow, 1'b0);
        checkOutput("reset out_data", out_data, '0);

        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].load_en, vecs[i].out_ready, vecs[i].in_res);
            checkOutput($sformatf("vec%0d in_ready", i), in_ready, vecs[i].exp_in_ready);
            checkOutput($sformatf("vec%0d out_valid", i), out_valid, vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d out_last", i), out_last, vecs[i].exp_last);
            checkOutput($sformatf("vec%0d overflow", i), overflow, vecs[i].exp_overflow);
            if (vecs[i].chk_data) checkOutput($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
        end

        doReset();
        for (int j = 0; j < 19; j++) begin
            applyStimulus(1'b1, 1'b0, pat(0, j));
            checkOutput($sformatf("gap valid j%0d", j), out_valid, j == 18);
            if (j < 18) applyStimulus(1'b0, 1'b0, pat(7, 99));
        end
        drainCheck(0, "gap");

        doReset();
        fillTile(0, 1'b0);
        checkOutput("pp tile0 in_ready", in_ready, 1'b1);
        checkOutput("pp tile0 valid", out_valid, 1'b1);
        fillTile(1000, 1'b0);
        checkOutput("pp both in_ready", in_ready, 1'b0);
        checkOutput("pp both valid", out_valid, 1'b1);
        checkOutput("pp both overflow", overflow, 1'b0);
        applyStimulus(1'b1, 1'b0, {BW{1'b1}});
        checkOutput("pp third overflow", overflow, 1'b1);
        checkOutput("pp third in_ready", in_ready, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("pp data %0d", i), out_data, row_exp(i < 4 ? 0 : 1000, i % 4));
            checkOutput($sformatf("pp last %0d", i), out_last, (i % 4) == 3);
            applyStimulus(1'b0, 1'b1, '0);
            checkOutput($sformatf("pp in_ready %0d", i), in_ready, i >= 3);
        end
        checkOutput("pp drained valid", out_valid, 1'b0);

        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, pat(0, k));
        checkOutput("rst sticky overflow", overflow, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0);
        rst = 1'b0;
        checkOutput("rst mid in_ready", in_ready, 1'b1);
        checkOutput("rst mid valid", out_valid, 1'b0);
        checkOutput("rst mid last", out_last, 1'b0);
        checkOutput("rst mid overflow", overflow, 1'b0);
        checkOutput("rst mid data", out_data, '0);
        fillTile(500, 1'b0);
        drainCheck(500, "rst fresh");

        doReset();
        fillTile(0, 1'b0);
        acc = 0;
        for (int t = 0; t < 10; t++) begin
            rdy = (t % 3 == 0);
            checkOutput($sformatf("bp valid t%0d", t), out_valid, acc < 4);
            if (acc < 4) begin
                checkOutput($sformatf("bp data t%0d", t), out_data, row_exp(0, acc));
                checkOutput($sformatf("bp last t%0d", t), out_last, acc == 3);
            end
            applyStimulus(1'b0, rdy, '0);
            if (rdy) acc++;
        end
        checkOutput("bp valid end", out_valid, 1'b0);

        doReset();
        fillTile(0, 1'b0);
        for (int k = 0; k < 19; k++) begin
            rdy = (k >= 15);
            if (rdy) checkOutput($sformatf("cc drain data k%0d", k), out_data, row_exp(0, k - 15));
            applyStimulus(1'b1, rdy, pat(1000, k));
        end
        checkOutput("cc valid", out_valid, 1'b1);
        checkOutput("cc in_ready", in_ready, 1'b1);
        checkOutput("cc last", out_last, 1'b0);
        drainCheck(1000, "cc tile1");

        doReset();
        for (int k = 0; k < 9; k++) begin
            load_en_b = 1'b1;
            in_res_b  = pat_b(k);
            tick();
            checkOutput($sformatf("sweep valid k%0d", k), out_valid_b, k == 8);
        end
        load_en_b   = 1'b0;
        out_ready_b = 1'b1;
        for (int r = 0; r < 2; r++) begin
            checkOutput($sformatf("sweep data r%0d", r), out_data_b, row_b(r));
            checkOutput($sformatf("sweep last r%0d", r), out_last_b, r == 1);
            tick();
        end
        checkOutput("sweep drained valid", out_valid_b, 1'b0);
        checkOutput("sweep in_ready", in_ready_b, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
